// File: rtl/tank_pkg.sv
// Shared constants for the tank game tick path: storage modes, direction codes and
// turn_sequencer FSM state encoding.
package tank_pkg;

  localparam logic [3:0] MODE_READ = 4'b0000;
  localparam logic [3:0] MODE_EDIT = 4'b1111;
  localparam logic [3:0] MODE_T1   = 4'b0001;
  localparam logic [3:0] MODE_T1P  = 4'b0011;
  localparam logic [3:0] MODE_T2   = 4'b0101;
  localparam logic [3:0] MODE_T2P  = 4'b0111;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LATCH = 4'd1;
  localparam logic [3:0] ST_T1    = 4'd2;
  localparam logic [3:0] ST_T1P   = 4'd3;
  localparam logic [3:0] ST_T2    = 4'd4;
  localparam logic [3:0] ST_T2P   = 4'd5;
  localparam logic [3:0] ST_HIT   = 4'd6;
  localparam logic [3:0] ST_SWEEP = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

endpackage

// File: rtl/turn_sequencer_if.sv
// Sequencer-to-board-storage bus: mode/address/data/load strobe out, result position/direction back.
interface turn_sequencer_if;
  logic [3:0] mode;
  logic [7:0] address;
  logic [7:0] data;
  logic       load_out;
  logic [7:0] updated_pos;
  logic [7:0] updated_dir;

  modport master (output mode, address, data, load_out, input updated_pos, updated_dir);
  modport slave  (input mode, address, data, load_out, output updated_pos, updated_dir);
endinterface

// File: rtl/player_input_latch.sv
// Sticky move/fire request capture with last-direction hold; flags update one cycle after input.
// No backpressure: requests are sampled only while sample is high and cleared by clear.
module player_input_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample,
  input  logic       clear,
  input  logic       move,
  input  logic [1:0] dir,
  input  logic       fire,
  output logic       move_flag,
  output logic       fire_flag,
  output logic [1:0] dir_q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      move_flag <= 1'b0;
      fire_flag <= 1'b0;
      dir_q     <= 2'd0;
    end else if (clear) begin
      move_flag <= 1'b0;
      fire_flag <= 1'b0;
    end else if (sample) begin
      if (move) begin
        move_flag <= 1'b1;
        dir_q     <= dir;
      end
      if (fire) fire_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Frame tick controller: latch inputs, step tanks/projectiles through storage, hit check, 256-cell sweep.
// Latency 260..276 cycles per frame; ticks arriving while busy are dropped and flagged via tick_missed.
module turn_sequencer
  import tank_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int PROJ_RANGE  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             p1_move,
  input  logic [1:0]       p1_dir,
  input  logic             p1_fire,
  input  logic             p2_move,
  input  logic [1:0]       p2_dir,
  input  logic             p2_fire,
  turn_sequencer_if.master stor,
  output logic             busy,
  output logic             frame_done,
  output logic             p1_hit,
  output logic             p2_hit,
  output logic             tick_missed
);

  localparam int KW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int CW = $clog2(PROJ_RANGE + 1);

  logic [3:0]    state, nxt;
  logic [KW-1:0] k;
  logic [7:0]    sweep_addr;
  logic          is_step, last_k;
  logic [3:0]    en;

  logic          p1_mv_s, p1_fr_s, p2_mv_s, p2_fr_s;
  logic [1:0]    p1_dir_q, p2_dir_q;
  logic          mv1_f, mv2_f;
  logic [7:0]    t1_pos, t2_pos;
  logic [1:0]    t1_dir, t2_dir;
  logic          pr1_act, pr2_act;
  logic [7:0]    pr1_pos, pr2_pos;
  logic [1:0]    pr1_dir, pr2_dir;
  logic [CW-1:0] pr1_cnt, pr2_cnt;
  logic          hit1_r, hit2_r;

  player_input_latch u_p1 (
    .clk(clk), .reset(reset), .sample(state == ST_IDLE), .clear(state == ST_LATCH),
    .move(p1_move), .dir(p1_dir), .fire(p1_fire),
    .move_flag(p1_mv_s), .fire_flag(p1_fr_s), .dir_q(p1_dir_q)
  );

  player_input_latch u_p2 (
    .clk(clk), .reset(reset), .sample(state == ST_IDLE), .clear(state == ST_LATCH),
    .move(p2_move), .dir(p2_dir), .fire(p2_fire),
    .move_flag(p2_mv_s), .fire_flag(p2_fr_s), .dir_q(p2_dir_q)
  );

  // First enabled step at or after index 'from'; disabled steps cost no cycles.
  function automatic logic [3:0] next_step(input logic [3:0] step_en, input logic [2:0] from);
    logic [3:0] s;
    s = ST_HIT;
    for (int i = 3; i >= 0; i--)
      if (i >= int'(from) && step_en[i]) s = ST_T1 + 4'(i);
    return s;
  endfunction

  assign is_step = (state == ST_T1) || (state == ST_T1P) || (state == ST_T2) || (state == ST_T2P);
  assign last_k  = (k == KW'(STEP_CYCLES - 1));

  // In LATCH the projectile flags are not yet updated, so fold in the pending fire requests.
  assign en = (state == ST_LATCH) ? {p2_fr_s | pr2_act, p2_mv_s, p1_fr_s | pr1_act, p1_mv_s}
                                  : {pr2_act, mv2_f, pr1_act, mv1_f};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (tick) nxt = ST_LATCH;
      ST_LATCH: nxt = next_step(en, 3'd0);
      ST_T1, ST_T1P, ST_T2, ST_T2P:
        if (last_k) nxt = next_step(en, 3'(state - ST_T1 + 4'd1));
      ST_HIT:   nxt = ST_SWEEP;
      ST_SWEEP: if (sweep_addr == 8'hFF) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stor.mode     = MODE_READ;
    stor.address  = 8'd0;
    stor.data     = 8'd0;
    stor.load_out = 1'b0;
    case (state)
      ST_T1:    begin stor.mode = MODE_T1;  stor.data = {6'b0, p1_dir_q}; end
      ST_T1P:   begin stor.mode = MODE_T1P; stor.data = {6'b0, pr1_dir};  end
      ST_T2:    begin stor.mode = MODE_T2;  stor.data = {6'b0, p2_dir_q}; end
      ST_T2P:   begin stor.mode = MODE_T2P; stor.data = {6'b0, pr2_dir};  end
      ST_SWEEP: begin stor.mode = MODE_EDIT; stor.address = sweep_addr;   end
      default:  ;
    endcase
    if (is_step) stor.load_out = (k == KW'(1));
  end

  assign busy        = (state != ST_IDLE);
  assign frame_done  = (state == ST_DONE);
  assign p1_hit      = (state == ST_DONE) && hit1_r;
  assign p2_hit      = (state == ST_DONE) && hit2_r;
  assign tick_missed = tick && busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      k          <= '0;
      sweep_addr <= 8'd0;
      mv1_f      <= 1'b0;
      mv2_f      <= 1'b0;
      t1_pos     <= 8'h00;
      t2_pos     <= 8'hFF;
      t1_dir     <= DIR_DOWN;
      t2_dir     <= DIR_UP;
      pr1_act    <= 1'b0;
      pr2_act    <= 1'b0;
      pr1_pos    <= 8'd0;
      pr2_pos    <= 8'd0;
      pr1_dir    <= 2'd0;
      pr2_dir    <= 2'd0;
      pr1_cnt    <= '0;
      pr2_cnt    <= '0;
      hit1_r     <= 1'b0;
      hit2_r     <= 1'b0;
    end else begin
      state      <= nxt;
      k          <= (is_step && !last_k) ? k + KW'(1) : '0;
      sweep_addr <= (state == ST_SWEEP) ? sweep_addr + 8'd1 : 8'd0;
      case (state)
        ST_LATCH: begin
          mv1_f  <= p1_mv_s;
          mv2_f  <= p2_mv_s;
          hit1_r <= 1'b0;
          hit2_r <= 1'b0;
          if (p1_fr_s && !pr1_act) begin
            pr1_act <= 1'b1;
            pr1_cnt <= '0;
            pr1_dir <= t1_dir;
            pr1_pos <= t1_pos;
          end
          if (p2_fr_s && !pr2_act) begin
            pr2_act <= 1'b1;
            pr2_cnt <= '0;
            pr2_dir <= t2_dir;
            pr2_pos <= t2_pos;
          end
        end
        ST_T1: if (last_k) begin
          t1_pos <= stor.updated_pos;
          t1_dir <= stor.updated_dir[1:0];
        end
        ST_T2: if (last_k) begin
          t2_pos <= stor.updated_pos;
          t2_dir <= stor.updated_dir[1:0];
        end
        // An unchanged position means the projectile hit a wall.
        ST_T1P: if (last_k) begin
          pr1_pos <= stor.updated_pos;
          pr1_dir <= stor.updated_dir[1:0];
          pr1_cnt <= pr1_cnt + CW'(1);
          if (stor.updated_pos == pr1_pos || pr1_cnt == CW'(PROJ_RANGE - 1)) pr1_act <= 1'b0;
        end
        ST_T2P: if (last_k) begin
          pr2_pos <= stor.updated_pos;
          pr2_dir <= stor.updated_dir[1:0];
          pr2_cnt <= pr2_cnt + CW'(1);
          if (stor.updated_pos == pr2_pos || pr2_cnt == CW'(PROJ_RANGE - 1)) pr2_act <= 1'b0;
        end
        ST_HIT: begin
          if (pr1_act && pr1_pos == t2_pos) begin
            hit2_r  <= 1'b1;
            pr1_act <= 1'b0;
          end
          if (pr2_act && pr2_pos == t1_pos) begin
            hit1_r  <= 1'b1;
            pr2_act <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
